axi_rd_4_splitter: RTL and testbench
====================================

AXI_RD_4_SPLITTER -- requirements
Module: axi_rd_4_splitter

Interface
REQ-001 IDWID, 4, width of all arid/rid fields.
REQ-002 DWID, 64, width of all rdata fields.
REQ-003 EXTRAS, 8, width of all arextras sideband fields.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 arid  input  IDWID  upstream AR id.
REQ-007 araddr  input  32  upstream AR address; [31:30] selects target.
REQ-008 arlen  input  8  upstream burst length minus one.
REQ-009 arextras  input  EXTRAS  upstream sideband, passed unchanged.
REQ-010 arburst  input  2  upstream burst type, passed unchanged.
REQ-011 arvalid  input  1  upstream AR valid.
REQ-012 arready  output  1  upstream AR ready.
REQ-013 rid  output  IDWID  upstream R id.
REQ-014 rdata  output  DWID  upstream R data.
REQ-015 rresp  output  2  upstream R response.
REQ-016 rlast  output  1  upstream R last beat.
REQ-017 rvalid  output  1  upstream R valid.
REQ-018 rready  input  1  upstream R ready.
REQ-019 x_arid, x_araddr, x_arlen, x_arextras, x_arburst, x_arvalid  output  as REQ-006..011  downstream AR, x = a,b,c,d.
REQ-020 x_arready  input  1  downstream AR ready, x = a,b,c,d.
REQ-021 x_rid, x_rdata, x_rresp, x_rlast, x_rvalid  input  as REQ-013..017  downstream R, x = a,b,c,d.
REQ-022 x_rready  output  1  downstream R ready, x = a,b,c,d.

Function
REQ-023 Decode SHALL be: araddr[31:30] = 0/1/2/3 selects a/b/c/d; the AR payload SHALL be forwarded combinationally to the selected port only.
REQ-024 x_arvalid SHALL equal arvalid AND (selected = x) AND NOT full; arready SHALL equal selected x_arready AND NOT full.
REQ-025 Each AR handshake SHALL push the 2-bit target into a 4-entry in-order tracking FIFO, making full = 4 entries outstanding.
REQ-026 The R channel SHALL be driven only from the port at FIFO head: rvalid = head x_rvalid AND NOT empty; head x_rready = rready; all other x_rready SHALL be 0.
REQ-027 The head entry SHALL be popped on an R handshake with rlast = 1; pop and push in the same cycle SHALL leave the count unchanged, including when full.
REQ-028 When empty, rvalid SHALL be 0, all x_rready SHALL be 0, and rid/rdata/rresp/rlast SHALL be 0.
REQ-029 FIFO read and write pointers SHALL be 2 bits and wrap 3 -> 0; the count SHALL be 3 bits (0..4).
REQ-030 Zero-cycle latency on both channels; no payload registering.

Reset
REQ-031 While rst = 1: FIFO count, pointers and the internal error-beat counter = 0; arready = 0; rvalid = 0; all x_arvalid = 0; all x_rready = 0; this SHALL take effect mid-burst with no completion of outstanding bursts.

Configuration
REQ-032 With AXI_RD_SPLIT_DECERR_EN defined: region 3 SHALL be unmapped; d_arvalid SHALL stay 0; the request SHALL be accepted internally (arready = NOT full), queued as target 3, and answered from the block with arlen+1 beats, rid = captured arid, rdata = 0, rresp = 2'b11, rlast on the final beat; the error beat counter SHALL be 8 bits. Without it, region 3 SHALL route to port d as in REQ-023.

Verification
REQ-033 araddr = 0x4000_0000, arlen = 3, b_arready = 1 -> b_arvalid pulses one cycle, four R beats from b reach upstream, FIFO returns to empty after b_rlast.
REQ-034 Four ARs to a, b, c, d with all R stalled -> fifth AR sees arready = 0 until the first rlast handshake from a.
REQ-035 c returns R before a while a is head -> c_rready = 0, rvalid = 0 until a responds; order a then c.
REQ-036 Full FIFO, rlast handshake and new AR in the same cycle -> both accepted, count stays 4.
REQ-037 rst asserted mid-burst (beat 2 of 8) -> all valids/readies low same cycle; after release, new AR to a is accepted with count 1.
REQ-038 AXI_RD_SPLIT_DECERR_EN: araddr = 0xC000_0000, arid = 5, arlen = 1 -> d_arvalid = 0, two beats rid = 5, rresp = 2'b11, rdata = 0, rlast on beat 2.

Source files
------------

// File: rtl/axi_rd_4_splitter_if.sv
// AXI read-channel bundle (AR + R) shared by the splitter's upstream port and its four downstream ports.
interface axi_rd_4_splitter_if #(
    parameter int IDWID  = 4,
    parameter int DWID   = 64,
    parameter int EXTRAS = 8
);
    logic [IDWID-1:0]  arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [EXTRAS-1:0] arextras;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [IDWID-1:0]  rid;
    logic [DWID-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arextras, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arextras, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_4_splitter.sv
// 1-to-4 AXI read splitter: araddr[31:30] picks port a/b/c/d, R beats return in issue order.
// Optional feature macro AXI_RD_SPLIT_DECERR_EN: region 3 is unmapped and answered locally with DECERR beats.
module axi_rd_4_splitter #(
    parameter int IDWID  = 4,
    parameter int DWID   = 64,
    parameter int EXTRAS = 8
) (
    input  logic                clk,
    input  logic                rst,
    axi_rd_4_splitter_if.slave  up,
    axi_rd_4_splitter_if.master a,
    axi_rd_4_splitter_if.master b,
    axi_rd_4_splitter_if.master c,
    axi_rd_4_splitter_if.master d
);
    localparam int PW = IDWID + 32 + 8 + EXTRAS + 2;

    logic [1:0]       sel, head, wptr, rptr;
    logic [2:0]       count;
    logic             empty, full, push, pop, tgt_ready;
    logic [1:0]       fifo_tgt [4];
    logic [3:0]       dn_arready, dn_arvalid, dn_rvalid, dn_rlast, dn_rready;
    logic [IDWID-1:0] dn_rid   [4];
    logic [DWID-1:0]  dn_rdata [4];
    logic [1:0]       dn_rresp [4];
    logic [PW-1:0]    up_payload;

    assign dn_arready = {d.arready, c.arready, b.arready, a.arready};
    assign dn_rvalid  = {d.rvalid, c.rvalid, b.rvalid, a.rvalid};
    assign dn_rlast   = {d.rlast, c.rlast, b.rlast, a.rlast};
    assign dn_rid     = '{a.rid, b.rid, c.rid, d.rid};
    assign dn_rdata   = '{a.rdata, b.rdata, c.rdata, d.rdata};
    assign dn_rresp   = '{a.rresp, b.rresp, c.rresp, d.rresp};
    assign {d.arvalid, c.arvalid, b.arvalid, a.arvalid} = dn_arvalid;
    assign {d.rready, c.rready, b.rready, a.rready}     = dn_rready;

    assign sel        = up.araddr[31:30];
    assign up_payload = {up.arid, up.araddr, up.arlen, up.arextras, up.arburst};
    assign {a.arid, a.araddr, a.arlen, a.arextras, a.arburst} = (sel == 2'd0) ? up_payload : '0;
    assign {b.arid, b.araddr, b.arlen, b.arextras, b.arburst} = (sel == 2'd1) ? up_payload : '0;
    assign {c.arid, c.araddr, c.arlen, c.arextras, c.arburst} = (sel == 2'd2) ? up_payload : '0;
`ifdef AXI_RD_SPLIT_DECERR_EN
    assign {d.arid, d.araddr, d.arlen, d.arextras, d.arburst} = '0;
`else
    assign {d.arid, d.araddr, d.arlen, d.arextras, d.arburst} = (sel == 2'd3) ? up_payload : '0;
`endif

    assign empty = (count == 3'd0);
    assign head  = fifo_tgt[rptr];
    assign push  = up.arvalid && up.arready;
    assign pop   = up.rvalid && up.rready && up.rlast;
    // A last beat retiring this cycle frees a slot, so a full FIFO can still accept.
    assign full  = (count == 3'd4) && !pop;

`ifdef AXI_RD_SPLIT_DECERR_EN
    logic [IDWID-1:0] fifo_id  [4];
    logic [7:0]       fifo_len [4];
    logic [7:0]       err_beat;
    logic             err_head, err_last;

    assign err_head = !empty && (head == 2'd3);
    assign err_last = (err_beat == fifo_len[rptr]);
`endif

    // R channel follows whichever target sits at the FIFO head.
    always_comb begin
        up.rvalid = 1'b0;
        up.rid    = '0;
        up.rdata  = '0;
        up.rresp  = '0;
        up.rlast  = 1'b0;
        dn_rready = '0;
        if (!empty) begin
            up.rvalid       = dn_rvalid[head];
            up.rid          = dn_rid[head];
            up.rdata        = dn_rdata[head];
            up.rresp        = dn_rresp[head];
            up.rlast        = dn_rlast[head];
            dn_rready[head] = up.rready;
`ifdef AXI_RD_SPLIT_DECERR_EN
            if (head == 2'd3) begin
                up.rvalid = 1'b1;
                up.rid    = fifo_id[rptr];
                up.rdata  = '0;
                up.rresp  = 2'b11;
                up.rlast  = err_last;
                dn_rready = '0;
            end
`endif
        end
    end

    always_comb begin
        dn_arvalid = '0;
        tgt_ready  = dn_arready[sel];
`ifdef AXI_RD_SPLIT_DECERR_EN
        if (sel == 2'd3) tgt_ready = 1'b1;
`endif
        up.arready = tgt_ready && !full && !rst;
        if (!full && !rst) dn_arvalid[sel] = up.arvalid;
`ifdef AXI_RD_SPLIT_DECERR_EN
        dn_arvalid[3] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
            wptr  <= 2'd0;
            rptr  <= 2'd0;
        end else begin
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // Entry storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tgt[wptr] <= sel;
`ifdef AXI_RD_SPLIT_DECERR_EN
            fifo_id[wptr]  <= up.arid;
            fifo_len[wptr] <= up.arlen;
`endif
        end
    end

`ifdef AXI_RD_SPLIT_DECERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       err_beat <= 8'd0;
        else if (err_head && up.rready) err_beat <= err_last ? 8'd0 : err_beat + 8'd1;
    end
`endif
endmodule

// File: tb/tb_axi_rd_4_splitter.sv
// Randomised and directed bench for axi_rd_4_splitter, checked every cycle against a queue-based model.
module tb_axi_rd_4_splitter;
    localparam int IDWID  = 4;
    localparam int DWID   = 64;
    localparam int EXTRAS = 8;
    localparam int PW     = IDWID + 32 + 8 + EXTRAS + 2;
`ifdef AXI_RD_SPLIT_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   check_count = 0;
    int   error_count = 0;

    logic [3:0]       s_arready, s_rvalid, s_rlast;
    logic [IDWID-1:0] s_rid   [4];
    logic [DWID-1:0]  s_rdata [4];
    logic [1:0]       s_rresp [4];
    logic [3:0]       o_arvalid, o_rready;
    logic [PW-1:0]    o_payload [4];

    // Model: outstanding requests in issue order, plus progress through a locally answered burst.
    int q_tgt[$];
    int q_id[$];
    int q_len[$];
    int m_err_beat = 0;
    bit m_push, m_pop, m_err_adv;

    always #5 clk = ~clk;

    axi_rd_4_splitter_if #(.IDWID(IDWID), .DWID(DWID), .EXTRAS(EXTRAS)) up_if (), a_if (), b_if (), c_if (), d_if ();

    axi_rd_4_splitter #(.IDWID(IDWID), .DWID(DWID), .EXTRAS(EXTRAS)) dut (
        .clk(clk), .rst(rst), .up(up_if), .a(a_if), .b(b_if), .c(c_if), .d(d_if)
    );

    assign {d_if.arready, c_if.arready, b_if.arready, a_if.arready} = s_arready;
    assign {d_if.rvalid, c_if.rvalid, b_if.rvalid, a_if.rvalid}     = s_rvalid;
    assign {d_if.rlast, c_if.rlast, b_if.rlast, a_if.rlast}         = s_rlast;
    assign {a_if.rid, a_if.rdata, a_if.rresp} = {s_rid[0], s_rdata[0], s_rresp[0]};
    assign {b_if.rid, b_if.rdata, b_if.rresp} = {s_rid[1], s_rdata[1], s_rresp[1]};
    assign {c_if.rid, c_if.rdata, c_if.rresp} = {s_rid[2], s_rdata[2], s_rresp[2]};
    assign {d_if.rid, d_if.rdata, d_if.rresp} = {s_rid[3], s_rdata[3], s_rresp[3]};
    assign o_arvalid = {d_if.arvalid, c_if.arvalid, b_if.arvalid, a_if.arvalid};
    assign o_rready  = {d_if.rready, c_if.rready, b_if.rready, a_if.rready};
    assign o_payload[0] = {a_if.arid, a_if.araddr, a_if.arlen, a_if.arextras, a_if.arburst};
    assign o_payload[1] = {b_if.arid, b_if.araddr, b_if.arlen, b_if.arextras, b_if.arburst};
    assign o_payload[2] = {c_if.arid, c_if.araddr, c_if.arlen, c_if.arextras, c_if.arburst};
    assign o_payload[3] = {d_if.arid, d_if.araddr, d_if.arlen, d_if.arextras, d_if.arburst};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic arvalid, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [3:0] arready, input logic rready);
        up_if.arvalid  = arvalid;
        up_if.araddr   = addr;
        up_if.arlen    = len;
        up_if.arid     = IDWID'($urandom);
        up_if.arextras = EXTRAS'($urandom);
        up_if.arburst  = 2'($urandom);
        up_if.rready   = rready;
        s_arready      = arready;
    endtask

    task automatic drive_r(input int port, input logic valid, input logic last);
        s_rvalid[port] = valid;
        s_rlast[port]  = last;
        s_rid[port]    = IDWID'($urandom);
        s_rdata[port]  = {$urandom, $urandom};
        s_rresp[port]  = 2'($urandom);
    endtask

    task automatic idle_r();
        for (int p = 0; p < 4; p++) drive_r(p, 1'b0, 1'b0);
    endtask

    task automatic reset_model();
        q_tgt.delete();
        q_id.delete();
        q_len.delete();
        m_err_beat = 0;
    endtask

    task automatic check_cycle();
        logic [3:0]       exp_arvalid, exp_rready;
        logic             exp_arready, exp_rvalid, exp_rlast, room, unmapped;
        logic [IDWID-1:0] exp_rid;
        logic [DWID-1:0]  exp_rdata;
        logic [1:0]       exp_rresp;
        int               sel;
        sel         = int'(up_if.araddr[31:30]);
        exp_rvalid  = 1'b0;
        exp_rlast   = 1'b0;
        exp_rid     = '0;
        exp_rdata   = '0;
        exp_rresp   = '0;
        exp_rready  = '0;
        m_err_adv   = 1'b0;
        if (q_tgt.size() > 0) begin
            if (DECERR && q_tgt[0] == 3) begin
                exp_rvalid = 1'b1;
                exp_rid    = IDWID'(q_id[0]);
                exp_rresp  = 2'b11;
                exp_rlast  = (m_err_beat == q_len[0]);
                m_err_adv  = up_if.rready;
            end else begin
                exp_rvalid = s_rvalid[q_tgt[0]];
                exp_rid    = s_rid[q_tgt[0]];
                exp_rdata  = s_rdata[q_tgt[0]];
                exp_rresp  = s_rresp[q_tgt[0]];
                exp_rlast  = s_rlast[q_tgt[0]];
                exp_rready[q_tgt[0]] = up_if.rready;
            end
        end
        m_pop       = exp_rvalid && up_if.rready && exp_rlast;
        unmapped    = DECERR && (sel == 3);
        room        = !rst && (q_tgt.size() < 4 || m_pop);
        exp_arready = room && (unmapped || s_arready[sel]);
        exp_arvalid = '0;
        if (room && !unmapped) exp_arvalid[sel] = up_if.arvalid;
        m_push = up_if.arvalid && exp_arready;

        checkOutput("arready", 64'(up_if.arready), 64'(exp_arready));
        checkOutput("x_arvalid", 64'(o_arvalid), 64'(exp_arvalid));
        checkOutput("x_rready", 64'(o_rready), 64'(exp_rready));
        checkOutput("rvalid", 64'(up_if.rvalid), 64'(exp_rvalid));
        checkOutput("rid", 64'(up_if.rid), 64'(exp_rid));
        checkOutput("rdata", 64'(up_if.rdata), 64'(exp_rdata));
        checkOutput("rresp", 64'(up_if.rresp), 64'(exp_rresp));
        checkOutput("rlast", 64'(up_if.rlast), 64'(exp_rlast));
        if (exp_arvalid[sel])
            checkOutput("ar_payload", 64'(o_payload[sel]),
                        64'({up_if.arid, up_if.araddr, up_if.arlen, up_if.arextras, up_if.arburst}));
    endtask

    task automatic update_model();
        if (m_pop) begin
            if (DECERR && q_tgt[0] == 3) m_err_beat = 0;
            void'(q_tgt.pop_front());
            void'(q_id.pop_front());
            void'(q_len.pop_front());
        end else if (m_err_adv) begin
            m_err_beat++;
        end
        if (m_push) begin
            q_tgt.push_back(int'(up_if.araddr[31:30]));
            q_id.push_back(int'(up_if.arid));
            q_len.push_back(int'(up_if.arlen));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        #1 check_cycle();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drain();
        applyStimulus(1'b0, 32'h0, 8'd0, 4'hF, 1'b1);
        for (int i = 0; i < 40 && q_tgt.size() > 0; i++) begin
            for (int p = 0; p < 4; p++) drive_r(p, 1'b1, 1'b1);
            step();
        end
        idle_r();
    endtask

    initial begin
        applyStimulus(1'b1, 32'h0, 8'd0, 4'hF, 1'b1);
        idle_r();
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Single 4-beat burst through port b, then b keeps rvalid high while the FIFO is empty.
        applyStimulus(1'b1, 32'h4000_0000, 8'd3, 4'b0010, 1'b1);
        step();
        applyStimulus(1'b0, 32'h4000_0000, 8'd3, 4'b0010, 1'b1);
        for (int beat = 0; beat < 4; beat++) begin
            drive_r(1, 1'b1, beat == 3);
            step();
        end
        drive_r(1, 1'b1, 1'b0);
        step();
        idle_r();

        // Fill with a,b,c,d; a fifth request stalls; c answering early is held off; a's last frees a slot.
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, {2'(t), 30'h0}, 8'd0, 4'hF, 1'b1);
            step();
        end
        applyStimulus(1'b1, 32'h0, 8'd0, 4'hF, 1'b1);
        step();
        step();
        drive_r(2, 1'b1, 1'b1);
        step();
        drive_r(0, 1'b1, 1'b1);
        step();
        drain();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)), 4'($urandom),
                          1'($urandom_range(0, 3) != 0));
            for (int p = 0; p < 4; p++) drive_r(p, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            step();
        end
        drain();

        // Reset lands on beat 2 of an 8-beat burst from a, with a new request pending.
        applyStimulus(1'b1, 32'h0, 8'd7, 4'hF, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 8'd7, 4'hF, 1'b1);
        drive_r(0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 32'h8000_0000, 8'd0, 4'hF, 1'b1);
        drive_r(0, 1'b1, 1'b0);
        rst = 1'b1;
        reset_model();
        step();
        rst = 1'b0;
        idle_r();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h0, 8'd0, 4'hF, 1'b1);
            step();
        end
        drain();

`ifdef AXI_RD_SPLIT_DECERR_EN
        applyStimulus(1'b1, 32'hC000_0000, 8'd1, 4'hF, 1'b1);
        up_if.arid = 4'd5;
        drive_r(3, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 8'd0, 4'hF, 1'b1);
        step();
        step();
        step();
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
